// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory responder: FSM state encoding and word size.
package mips_mem_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mips_mem_array.sv
// Unified word memory: three combinational read ports and one synchronous write port.
// The write port is shared by the loader and the core; the FSM state picks the owner.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic            clk,
    input  logic [1:0]      state_i,
    input  logic            load_we_i,
    input  logic [AW-1:0]   load_idx_i,
    input  logic [31:0]     load_data_i,
    input  logic            core_we_i,
    input  logic [AW-1:0]   core_idx_i,
    input  logic [31:0]     core_data_i,
    input  logic [3*AW-1:0] rd_idx_i,
    output logic [95:0]     rd_data_o
);

    // Contents are deliberately not reset so a program survives a reset pulse.
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if (state_i == S_LOAD) begin
            wr_en   = load_we_i;
            wr_idx  = load_idx_i;
            wr_data = load_data_i;
        end else if (state_i == S_RUN) begin
            wr_en   = core_we_i;
            wr_idx  = core_idx_i;
            wr_data = core_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
            assign rd_data_o[gi*32 +: 32] = mem_q[rd_idx_i[gi*AW +: AW]];
        end
    endgenerate

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the dual-issue MIPS core: 64-bit fetch, one data port,
// and a streaming program loader that holds the core in reset while it fills memory.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    input  logic          reload,
    output logic          core_rst,
    input  logic [31:0]   inst_adr,
    output logic [63:0]   inst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [31:0]   data_adr,
    input  logic [31:0]   data_out,
    output logic [31:0]   data_in,
    output logic [AW:0]   load_count,
    output logic          err_misalign,
    output logic          err_range,
    output logic          err_ovf
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH_WORDS - 1);

    logic [1:0]  state_q, state_d;
    logic [AW:0] count_q, count_d;
    logic        core_rst_q, load_ready_q;
    logic        err_mis_q, err_mis_d;
    logic        err_rng_q, err_rng_d;
    logic        err_ovf_q, err_ovf_d;

    logic          run;
    logic          load_acc;
    logic          load_at_end;
    logic          data_mis;
    logic          data_oor;
    logic          fetch_oor;
    logic          data_access;
    logic          core_wr_ok;
    logic [AW-1:0] fetch_idx0;
    logic [AW-1:0] fetch_idx1;
    logic [AW-1:0] data_idx;
    logic [95:0]   rd_data;
    logic          unused_inst_lsb;

    assign run         = (state_q == S_RUN);
    assign load_acc    = load_ready_q & load_valid;
    assign load_at_end = (count_q == LAST_IDX);

    assign data_mis    = |data_adr[1:0];
    assign data_oor    = |data_adr[31:AW+2];
    assign fetch_oor   = |inst_adr[31:AW+2];
    assign data_access = mem_read | mem_write;
    assign core_wr_ok  = run & mem_write & ~data_mis & ~data_oor;

    // Lane 2 index wraps modulo the memory depth; both lanes share the range test.
    assign fetch_idx0      = inst_adr[AW+1:2];
    assign fetch_idx1      = fetch_idx0 + 1'b1;
    assign data_idx        = data_adr[AW+1:2];
    assign unused_inst_lsb = ^inst_adr[1:0];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        err_mis_d = err_mis_q;
        err_rng_d = err_rng_q;
        err_ovf_d = err_ovf_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_LOAD;
                count_d = '0;
            end
            S_LOAD: begin
                if (load_acc) begin
                    count_d = count_q + 1'b1;
                    if (load_last || load_at_end) begin
                        state_d = S_RELEASE;
                    end
                    if (load_at_end && !load_last) begin
                        err_ovf_d = 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (reload) begin
                    state_d   = S_LOAD;
                    count_d   = '0;
                    err_mis_d = 1'b0;
                    err_rng_d = 1'b0;
                    err_ovf_d = 1'b0;
                end else begin
                    if (data_access && data_mis) begin
                        err_mis_d = 1'b1;
                    end
                    if ((data_access && data_oor) || fetch_oor) begin
                        err_rng_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // core_rst and load_ready are registered from next state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            core_rst_q   <= 1'b1;
            load_ready_q <= 1'b0;
            err_mis_q    <= 1'b0;
            err_rng_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            core_rst_q   <= (state_d != S_RUN);
            load_ready_q <= (state_d == S_LOAD);
            err_mis_q    <= err_mis_d;
            err_rng_q    <= err_rng_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    mips_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk        (clk),
        .state_i    (state_q),
        .load_we_i  (load_acc),
        .load_idx_i (count_q[AW-1:0]),
        .load_data_i(load_data),
        .core_we_i  (core_wr_ok),
        .core_idx_i (data_idx),
        .core_data_i(data_out),
        .rd_idx_i   ({data_idx, fetch_idx1, fetch_idx0}),
        .rd_data_o  (rd_data)
    );

    assign inst         = fetch_oor ? 64'h0 : rd_data[63:0];
    assign data_in      = (mem_read && !data_oor) ? rd_data[95:64] : 32'h0;
    assign core_rst     = core_rst_q;
    assign load_ready   = load_ready_q;
    assign load_count   = count_q;
    assign err_misalign = err_mis_q;
    assign err_range    = err_rng_q;
    assign err_ovf      = err_ovf_q;

endmodule
